// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined LEGv8 immediate generator for the decode stage.
// Decodes D, CB, B, I and IW immediates (anything else is sign-extended as a
// raw 32-bit word) and presents them through a valid/ready stage. A skid
// register lets decode stall without a combinational ready path.
// Optional feature macro: BYTE_OFFSET_EN -- when defined, CB and B results
// are scaled to byte offsets (shifted left by 2); otherwise they are word offsets.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt
);

  // Encoding chosen so out_valid and in_ready are single state-flop bits.
  typedef enum logic [1:0] {
    ST_E = 2'b00,
    ST_O = 2'b01,
    ST_F = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic                 drain;
  logic                 ld_or_in;
  logic                 ld_or_sr;
  logic                 ld_sr;

  logic signed [63:0]   dec_imm_p0;
  logic [FMT_W-1:0]     dec_fmt_p0;

  logic [XLEN-1:0]      or_imm_p1;
  logic [FMT_W-1:0]     or_fmt_p1;
  logic [XLEN-1:0]      sr_imm_p1;
  logic [FMT_W-1:0]     sr_fmt_p1;

  // Branch displacements are word offsets unless byte scaling is built in.
  function automatic logic signed [63:0] branch_scale(input logic signed [63:0] v);
`ifdef BYTE_OFFSET_EN
    return v <<< 2;
`else
    return v;
`endif
  endfunction

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // ---- stage p0: combinational immediate decode, first match wins ----
  // Decode the immediate at 64 bits; truncation to XLEN happens on capture.
  always_comb begin
    dec_imm_p0 = {{32{in_instr[31]}}, in_instr};
    dec_fmt_p0 = FMT_W'(0);
    if (in_instr[31:24] == 8'hB4 || in_instr[31:24] == 8'hB5 ||
        in_instr[31:24] == 8'h54) begin
      dec_imm_p0 = branch_scale({{45{in_instr[23]}}, in_instr[23:5]});
      dec_fmt_p0 = FMT_W'(2);
    end else if (in_instr[31:26] == 6'b000101 || in_instr[31:26] == 6'b100101) begin
      dec_imm_p0 = branch_scale({{38{in_instr[25]}}, in_instr[25:0]});
      dec_fmt_p0 = FMT_W'(3);
    end else if (in_instr[31:21] == 11'h7C2 || in_instr[31:21] == 11'h7C0) begin
      dec_imm_p0 = {{55{in_instr[20]}}, in_instr[20:12]};
      dec_fmt_p0 = FMT_W'(1);
    end else if (in_instr[31:22] == 10'h244 || in_instr[31:22] == 10'h344) begin
      dec_imm_p0 = {52'd0, in_instr[21:10]};
      dec_fmt_p0 = FMT_W'(4);
    end else if (in_instr[31:23] == 9'h1A5 || in_instr[31:23] == 9'h1E5) begin
      dec_imm_p0 = {48'd0, in_instr[20:5]} << {in_instr[22:21], 4'd0};
      dec_fmt_p0 = FMT_W'(5);
    end
  end

  // Next entry state and register load enables; flush overrides any transfer in.
  always_comb begin
    state_d  = state_q;
    ld_or_in = 1'b0;
    ld_or_sr = 1'b0;
    ld_sr    = 1'b0;
    case (state_q)
      ST_E: begin
        if (accept) begin
          ld_or_in = 1'b1;
          state_d  = ST_O;
        end
      end
      ST_O: begin
        if (accept && drain) begin
          ld_or_in = 1'b1;
        end else if (accept) begin
          ld_sr   = 1'b1;
          state_d = ST_F;
        end else if (drain) begin
          state_d = ST_E;
        end
      end
      ST_F: begin
        if (drain) begin
          ld_or_sr = 1'b1;
          state_d  = ST_O;
        end
      end
      default: state_d = ST_E;
    endcase
    if (flush) begin
      state_d  = ST_E;
      ld_or_in = 1'b0;
      ld_or_sr = 1'b0;
      ld_sr    = 1'b0;
    end
  end

  // Entry-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_E;
    else     state_q <= state_d;
  end

  // ---- stage p1: output register and skid register ----
  // Data holds whenever no load is enabled, so a stalled or flushed output stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_imm_p1 <= '0;
      or_fmt_p1 <= '0;
      sr_imm_p1 <= '0;
      sr_fmt_p1 <= '0;
    end else begin
      if (ld_or_in) begin
        or_imm_p1 <= dec_imm_p0[XLEN-1:0];
        or_fmt_p1 <= dec_fmt_p0;
      end else if (ld_or_sr) begin
        or_imm_p1 <= sr_imm_p1;
        or_fmt_p1 <= sr_fmt_p1;
      end
      if (ld_sr) begin
        sr_imm_p1 <= dec_imm_p0[XLEN-1:0];
        sr_fmt_p1 <= dec_fmt_p0;
      end
    end
  end

  assign out_imm = or_imm_p1;
  assign out_fmt = or_fmt_p1;

endmodule
